shot_ctrl: RTL

- Upstream stage of the bullet manager: turns raw fire buttons into clean, rate-limited one-cycle shoot requests on the frame clock.
- Synchronises and debounces both buttons, enforces a cooldown between shots, and suppresses shots when all four bullet slots report in use.
- Outputs drive the bullet manager's shootUp/shootDown inputs directly; bullet_in_use is fed back from its inUse vector.

---
 rtl/shot_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/shot_ctrl.sv
// ---------------------------------------------------------------------------
// shot_ctrl
// Turns two raw fire buttons into clean, rate-limited one-cycle shoot
// requests for the bullet manager, on the 60 Hz frame clock.
//
// Each button goes through a two-flop synchroniser and a debouncer. A rising
// edge of a debounced level is a fire request. Up beats down when both
// request together. A request fires only if at least one bullet slot is
// free. It is followed by a cooldown during which new requests are dropped.
//
// Build option:
//   AUTOFIRE_EN  when defined, a debounced level that is still high counts as
//                a request, so a held button fires every COOLDOWN+1 frames.
//
// Parameters:
//   DEBOUNCE  1..15  frames a synced level must disagree before it is taken
//   COOLDOWN  0..255 frames after a fire pulse with no new shot
//
// Ports:
//   clk_60hz       in   frame clock
//   reset          in   synchronous, active-high reset
//   btn_up         in   raw fire-up button (asynchronous)
//   btn_down       in   raw fire-down button (asynchronous)
//   bullet_in_use  in   [3:0] per-slot busy flags from the bullet manager
//   shoot_up       out  one-cycle fire-up pulse
//   shoot_down     out  one-cycle fire-down pulse
//   busy           out  high in FIRE or COOLDOWN
//   dry_fire       out  one-cycle pulse when a request meets four busy slots
//   shot_count     out  [7:0] shots issued, wraps 255 -> 0
// ---------------------------------------------------------------------------
// state    | meaning
// ST_IDLE  | waiting for a request
// ST_FIRE  | shoot pulse is high this cycle
// ST_COOL  | cooldown counter running, requests dropped
// ---------------------------------------------------------------------------
module shot_ctrl #(
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned COOLDOWN = 8
) (
   input  logic       clk_60hz,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [3:0] bullet_in_use,
   output logic       shoot_up,
   output logic       shoot_down,
   output logic       busy,
   output logic       dry_fire,
   output logic [7:0] shot_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FIRE = 2'd1;
   localparam logic [1:0] ST_COOL = 2'd2;

   // The flip happens on the edge that would take the count to DEBOUNCE.
   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
   localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN);

   // Bit 0 carries the up button, bit 1 the down button.
   logic [1:0] w_raw;
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_deb;
   logic [1:0] r_deb_d;
   logic [3:0] r_deb_cnt [2];

   logic [1:0] r_state;
   logic [7:0] r_cd_cnt;
   logic       r_shoot_up;
   logic       r_shoot_down;
   logic       r_dry;
   logic [7:0] r_shot_cnt;

   logic [1:0] w_req;
   logic       w_any_req;
   logic       w_full;
   logic       w_exit;
   logic       w_can_issue;

   assign w_raw = {btn_down, btn_up};

   always_ff @(posedge clk_60hz) begin
      if (reset) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_deb        <= '0;
         r_deb_d      <= '0;
         r_deb_cnt[0] <= '0;
         r_deb_cnt[1] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_deb[i]     <= ~r_deb[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
            end
         end
      end
   end

`ifdef AUTOFIRE_EN
   assign w_req = r_deb;
`else
   assign w_req = r_deb & ~r_deb_d;
`endif

   assign w_any_req = |w_req;
   assign w_full    = &bullet_in_use;

   // Last busy cycle: the edge that would otherwise return to IDLE.
   assign w_exit = ((r_state == ST_COOL) && (r_cd_cnt == 8'd1)) ||
                   ((r_state == ST_FIRE) && (CD_LOAD == 8'd0));

   // With autofire the exit edge can issue straight away, which keeps a held
   // button on an exact COOLDOWN+1 frame period instead of COOLDOWN+2.
`ifdef AUTOFIRE_EN
   assign w_can_issue = (r_state == ST_IDLE) || w_exit;
`else
   assign w_can_issue = (r_state == ST_IDLE);
`endif

   always_ff @(posedge clk_60hz) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cd_cnt     <= '0;
         r_shoot_up   <= 1'b0;
         r_shoot_down <= 1'b0;
         r_dry        <= 1'b0;
         r_shot_cnt   <= '0;
      end else begin
         r_shoot_up   <= 1'b0;
         r_shoot_down <= 1'b0;
         r_dry        <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_FIRE: begin
               if (CD_LOAD == 8'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state  <= ST_COOL;
                  r_cd_cnt <= CD_LOAD;
               end
            end
            ST_COOL: begin
               if (r_cd_cnt == 8'd1) begin
                  r_state  <= ST_IDLE;
                  r_cd_cnt <= '0;
               end else begin
                  r_cd_cnt <= r_cd_cnt - 8'd1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cd_cnt <= '0;
            end
         endcase

         // Placed after the case so an issue on the exit edge overrides the
         // return to IDLE.
         if (w_can_issue && w_any_req) begin
            if (!w_full) begin
               r_state      <= ST_FIRE;
               r_shoot_up   <= w_req[0];
               r_shoot_down <= ~w_req[0];
               r_shot_cnt   <= r_shot_cnt + 8'd1;
            end else begin
               r_dry <= 1'b1;
            end
         end
      end
   end

   assign shoot_up   = r_shoot_up;
   assign shoot_down = r_shoot_down;
   assign dry_fire   = r_dry;
   assign busy       = (r_state == ST_FIRE) || (r_state == ST_COOL);
   assign shot_count = r_shot_cnt;

endmodule
